// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the pipeline MEM stage (cpu_*)
// and the external loader/debug port (ext_*). One access is granted per
// cycle, combinationally, in the request cycle. The synchronous read data is
// steered back to whichever requester issued the read one cycle earlier,
// using a small return-tag register.
//
// Contention policy:
//   - The CPU normally wins when both sides request.
//   - With DMEM_ARB_STARVE_EN defined, a starvation counter tracks how many
//     consecutive cycles the external port has been denied. Once it reaches
//     STARVE_MAX, the external port wins one cycle and the counter restarts.
//   - With DMEM_ARB_STARVE_EN undefined, priority is fixed: the external port
//     is granted only in cycles where cpu_req is low.
//
// Configuration macro: DMEM_ARB_STARVE_EN (undefined by default).
//
// Parameters:
//   DATA_W      memory word width
//   ADDR_W      byte address width
//   STARVE_MAX  denied cycles before the external port wins (1..15)
//
// Ports:
//   clk, arst                   clock, asynchronous active-high reset
//   cpu_req/wen/addr/wdata      MEM-stage request, held until granted
//   cpu_stall                   cpu_req high but the CPU lost this cycle
//   cpu_rvalid/rdata            CPU read return, one cycle after grant
//   ext_req/wen/addr/wdata      external request, held until ext_gnt
//   ext_gnt                     external request accepted this cycle
//   ext_rvalid/rdata            external read return, one cycle after grant
//   mem_addr/wen/ren/wdata      command to the SRAM (all zero with no grant)
//   mem_rdata                   SRAM read data, valid the cycle after mem_ren
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              arst,

    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The starvation counter is 4 bits wide, so the limit must fit in it and
    // must be non-zero (a zero limit would hand every contended cycle to the
    // external port).
    generate
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
            $error("dmem_arbiter: STARVE_MAX must be in the range 1..15");
        end
    endgenerate

    // Owner of the read issued in the previous cycle.
    typedef enum logic [1:0] {
        RTAG_NONE = 2'b00,
        RTAG_CPU  = 2'b01,
        RTAG_EXT  = 2'b10
    } rtag_t;

    rtag_t rtag_reg;
    rtag_t rtag_next;

    logic  cpu_granted;
    logic  ext_granted;
    logic  starve_hit;     // external port has waited long enough to win

    // ------------------------------------------------------------------------
    // Starvation counter
    // ------------------------------------------------------------------------
`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_reg;
    logic [3:0] starve_cnt_next;

    // Counts consecutive cycles in which the external port asks and loses.
    // An external grant clears it on the same edge, so the override lasts
    // exactly one cycle and the CPU then gets the next STARVE_MAX contended
    // cycles again.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!ext_req || ext_granted) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            starve_cnt_reg <= 4'd0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    assign starve_hit = (starve_cnt_reg == STARVE_LIM);
`else
    // Fixed priority: the CPU never yields under contention.
    assign starve_hit = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arbitration (combinational, same cycle as the request)
    // ------------------------------------------------------------------------
    // The CPU loses only when the external port is also asking and has been
    // starved up to the limit. The external port wins when it is alone or
    // when it holds the starvation override.
    always_comb begin
        cpu_granted = cpu_req & ~(ext_req & starve_hit);
        ext_granted = ext_req & (~cpu_req | starve_hit);
    end

    assign cpu_stall = cpu_req & ~cpu_granted;
    assign ext_gnt   = ext_req & ext_granted;

    // ------------------------------------------------------------------------
    // Memory command mux; everything is driven to zero with no grant so the
    // SRAM sees a clean idle bus.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        if (cpu_granted) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wen   = cpu_wen;
            mem_ren   = ~cpu_wen;
        end else if (ext_granted) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
            mem_wen   = ext_wen;
            mem_ren   = ~ext_wen;
        end
    end

    // ------------------------------------------------------------------------
    // Return-tag FSM: state register
    // ------------------------------------------------------------------------
    // Asynchronous clear drops any in-flight return at once; the data that
    // the SRAM still delivers next cycle is never flagged valid.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rtag_reg <= RTAG_NONE;
        end else begin
            rtag_reg <= rtag_next;
        end
    end

    // ------------------------------------------------------------------------
    // Return-tag FSM: next state
    // ------------------------------------------------------------------------
    // Rewritten every cycle, so back-to-back reads from different owners each
    // carry their own tag and writes or idle cycles leave no stale tag.
    always_comb begin
        rtag_next = RTAG_NONE;
        if (cpu_granted && !cpu_wen) begin
            rtag_next = RTAG_CPU;
        end else if (ext_granted && !ext_wen) begin
            rtag_next = RTAG_EXT;
        end
    end

    // ------------------------------------------------------------------------
    // Return-tag FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        cpu_rvalid = 1'b0;
        ext_rvalid = 1'b0;
        case (rtag_reg)
            RTAG_CPU: cpu_rvalid = 1'b1;
            RTAG_EXT: ext_rvalid = 1'b1;
            default: begin
                cpu_rvalid = 1'b0;
                ext_rvalid = 1'b0;
            end
        endcase
    end

    // Read data is gated by its valid so the non-owner always sees zero.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rdata_gate
            assign cpu_rdata[gi] = mem_rdata[gi] & cpu_rvalid;
            assign ext_rdata[gi] = mem_rdata[gi] & ext_rvalid;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural SRAM sits on the mem_*
// port. A reference model tracks who should win each cycle (from the
// request pattern and a count of consecutive external denials), which read
// return is pending, and a shadow copy of memory contents. Directed steps
// cover reset, single reads, interleaved reads, writes and contention,
// followed by a randomized phase that obeys the hold-until-granted handshake.
// Follows DMEM_ARB_STARVE_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int DW   = 64;
    localparam int AW   = 64;
    localparam int SMAX = 4;

`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst;
    logic          cpu_req, cpu_wen;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ext_req, ext_wen;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wen, mem_ren;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk       (clk),
        .arst      (arst),
        .cpu_req   (cpu_req),
        .cpu_wen   (cpu_wen),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .ext_req   (ext_req),
        .ext_wen   (ext_wen),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_gnt   (ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata (ext_rdata),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_ren   (mem_ren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // ---------------------------------------------------------------- SRAM
    function automatic logic [63:0] preload(input int idx);
        case (idx)
            1:       return 64'h0000_0000_0000_0055;
            2:       return 64'hDEAD_BEEF_0000_0001;
            3:       return 64'h0000_0000_0000_00AA;
            default: return {32'hC0DE_0000 | 32'(idx), ~32'(idx)};
        endcase
    endfunction

    bit [63:0] sram_data [128];
    bit        sram_written [128];

    always @(posedge clk) begin
        if (mem_ren)
            mem_rdata <= sram_written[mem_addr[9:3]] ? sram_data[mem_addr[9:3]]
                                                     : preload(int'(mem_addr[9:3]));
        if (mem_wen) begin
            sram_data[mem_addr[9:3]]    <= mem_wdata;
            sram_written[mem_addr[9:3]] <= 1'b1;
        end
    end

    // ---------------------------------------------------------------- model
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          m_starve;            // consecutive external denials
    int          pend_owner;          // 0 none, 1 cpu, 2 ext
    logic [63:0] pend_data;
    logic [63:0] shadow [128];
    bit          cpu_done, ext_done;  // granted in the last step

    // snapshots of the last checked cycle for directed expectations
    logic        s_cpu_stall, s_ext_gnt, s_mem_wen, s_mem_ren;
    logic        s_cpu_rvalid, s_ext_rvalid;
    logic [63:0] s_cpu_rdata, s_ext_rdata, s_mem_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Winner: 0 none, 1 cpu, 2 ext.
    function automatic int pick(input bit c, input bit e, input int starve);
        if (c && e) return (STARVE_EN && starve >= SMAX) ? 2 : 1;
        if (c)      return 1;
        if (e)      return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_starve   = 0;
        pend_owner = 0;
        pend_data  = '0;
    endtask

    // One clock cycle with the inputs currently driven: check at negedge,
    // then advance the model after the rising edge.
    task automatic step();
        int          win;
        bit          c_req, e_req, w;
        logic [63:0] a, d;
        @(negedge clk);
        c_req = cpu_req;
        e_req = ext_req;
        win   = pick(c_req, e_req, m_starve);
        w     = (win == 1) ? cpu_wen : ext_wen;
        a     = (win == 1) ? cpu_addr : (win == 2) ? ext_addr : 64'd0;
        d     = (win == 1) ? cpu_wdata : (win == 2) ? ext_wdata : 64'd0;

        s_cpu_stall  = cpu_stall;   s_ext_gnt    = ext_gnt;
        s_mem_wen    = mem_wen;     s_mem_ren    = mem_ren;
        s_mem_wdata  = mem_wdata;
        s_cpu_rvalid = cpu_rvalid;  s_cpu_rdata  = cpu_rdata;
        s_ext_rvalid = ext_rvalid;  s_ext_rdata  = ext_rdata;

        check("cpu_stall",  cpu_stall,  64'(c_req && win != 1));
        check("ext_gnt",    ext_gnt,    64'(win == 2));
        check("mem_wen",    mem_wen,    64'(win != 0 && w));
        check("mem_ren",    mem_ren,    64'(win != 0 && !w));
        check("mem_addr",   mem_addr,   a);
        check("mem_wdata",  mem_wdata,  d);
        check("cpu_rvalid", cpu_rvalid, 64'(pend_owner == 1));
        check("cpu_rdata",  cpu_rdata,  (pend_owner == 1) ? pend_data : 64'd0);
        check("ext_rvalid", ext_rvalid, 64'(pend_owner == 2));
        check("ext_rdata",  ext_rdata,  (pend_owner == 2) ? pend_data : 64'd0);
        $display("cyc %0d cpu_req=%0b ext_req=%0b winner=%0d wen=%0b addr=%h rv_cpu=%0b rv_ext=%0b",
                 cyc, c_req, e_req, win, w, a, cpu_rvalid, ext_rvalid);

        @(posedge clk);
        #1;
        if (STARVE_EN && e_req && win != 2)
            m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
        else
            m_starve = 0;
        pend_owner = (win != 0 && !w) ? win : 0;
        pend_data  = shadow[a[9:3]];
        if (win != 0 && w) shadow[a[9:3]] = d;
        cpu_done = (win == 1);
        ext_done = (win == 2);
        cyc++;
    endtask

    task automatic set_cpu(input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
        cpu_req = r; cpu_wen = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_ext(input bit r, input bit w, input logic [63:0] a, input logic [63:0] d);
        ext_req = r; ext_wen = w; ext_addr = a; ext_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        for (int i = 0; i < 128; i++) shadow[i] = preload(i);
        model_reset();
        cpu_done = 1'b1;
        ext_done = 1'b1;
        arst = 1'b1;
        set_cpu(0, 0, 0, 0);
        set_ext(0, 0, 0, 0);

        // Reset: combinational path follows inputs, registered outputs idle.
        @(negedge clk);
        set_cpu(1, 0, 64'h10, 0);
        #1;
        check("rst_mem_ren",    mem_ren,    64'd1);
        check("rst_cpu_stall",  cpu_stall,  64'd0);
        check("rst_cpu_rvalid", cpu_rvalid, 64'd0);
        check("rst_ext_rvalid", ext_rvalid, 64'd0);
        set_cpu(0, 0, 0, 0);
        @(posedge clk);
        #2 arst = 1'b0;
        step();

        // Single CPU read of 0x10.
        set_cpu(1, 0, 64'h10, 0);
        step();
        check("rd_mem_ren",   s_mem_ren,   64'd1);
        check("rd_cpu_stall", s_cpu_stall, 64'd0);
        set_cpu(0, 0, 0, 0);
        step();
        check("rd_cpu_rvalid", s_cpu_rvalid, 64'd1);
        check("rd_cpu_rdata",  s_cpu_rdata,  64'hDEAD_BEEF_0000_0001);
        check("rd_ext_rvalid", s_ext_rvalid, 64'd0);

        // Interleaved reads: ext 0x8 then CPU 0x18.
        set_ext(1, 0, 64'h8, 0);
        step();
        set_ext(0, 0, 0, 0);
        set_cpu(1, 0, 64'h18, 0);
        step();
        check("il_ext_rvalid", s_ext_rvalid, 64'd1);
        check("il_ext_rdata",  s_ext_rdata,  64'h55);
        check("il_cpu_rvalid1", s_cpu_rvalid, 64'd0);
        set_cpu(0, 0, 0, 0);
        step();
        check("il_cpu_rvalid", s_cpu_rvalid, 64'd1);
        check("il_cpu_rdata",  s_cpu_rdata,  64'hAA);
        check("il_ext_rvalid2", s_ext_rvalid, 64'd0);

        // External write, then CPU read-back.
        set_ext(1, 1, 64'h20, 64'h1234);
        step();
        check("wr_mem_wen",   s_mem_wen,   64'd1);
        check("wr_mem_wdata", s_mem_wdata, 64'h1234);
        set_ext(0, 0, 0, 0);
        step();
        check("wr_no_cpu_rvalid", s_cpu_rvalid, 64'd0);
        check("wr_no_ext_rvalid", s_ext_rvalid, 64'd0);
        set_cpu(1, 0, 64'h20, 0);
        step();
        set_cpu(0, 0, 0, 0);
        step();
        check("wr_readback", s_cpu_rdata, 64'h1234);

        // Contention: both sides read continuously for 20 cycles.
        set_cpu(1, 0, 64'h18, 0);
        set_ext(1, 0, 64'h8, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            check("cont_ext_gnt",   s_ext_gnt,   64'(STARVE_EN && (k % (SMAX + 1)) == SMAX));
            check("cont_cpu_stall", s_cpu_stall, 64'(STARVE_EN && (k % (SMAX + 1)) == SMAX));
        end
        set_cpu(0, 0, 0, 0);
        step();
        check("cont_release_gnt", s_ext_gnt, 64'd1);
        set_ext(0, 0, 0, 0);
        step();

        // Reset asserted while a CPU read return is pending.
        set_cpu(1, 0, 64'h10, 0);
        step();
        set_cpu(0, 0, 0, 0);
        check("mid_rvalid_before", cpu_rvalid, 64'd1);
        arst = 1'b1;
        #1;
        check("mid_rvalid_after", cpu_rvalid, 64'd0);
        check("mid_rdata_after",  cpu_rdata,  64'd0);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #2 arst = 1'b0;
        step();

        // Randomized traffic honouring hold-until-granted.
        cpu_done = 1'b1;
        ext_done = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (!cpu_req || cpu_done)
                set_cpu($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                        64'($urandom_range(0, 127)) << 3, {$urandom, $urandom});
            if (!ext_req || ext_done)
                set_ext($urandom_range(0, 9) < 5, $urandom_range(0, 2) == 0,
                        64'($urandom_range(0, 127)) << 3, {$urandom, $urandom});
            step();
        end
        set_cpu(0, 0, 0, 0);
        set_ext(0, 0, 0, 0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
